// File: rtl/cc_row_shiftregister.sv
// cc_row_shiftregister: registered row stage behind CC_MUX41.
// Captures a row word and rotates it left/right once every TICKDIV
// qualifying ticks, flagging a one-cycle wrap pulse when a set bit
// crosses the row edge. All outputs are driven straight from registers.
module cc_row_shiftregister #(
    parameter int ROWSHIFT_DATAWIDTH = 8,
    parameter int ROWSHIFT_TICKDIV   = 4
) (
    input  logic                          CC_ROWSHIFT_CLOCK_50,
    input  logic                          CC_ROWSHIFT_RESET_InHigh,
    input  logic [ROWSHIFT_DATAWIDTH-1:0] CC_ROWSHIFT_data_InBUS,
    input  logic [1:0]                    CC_ROWSHIFT_mode_InBUS,
    input  logic                          CC_ROWSHIFT_tick_InHigh,
    output logic [ROWSHIFT_DATAWIDTH-1:0] CC_ROWSHIFT_data_OutBUS,
    output logic                          CC_ROWSHIFT_wrap_OutHigh,
    output logic [7:0]                    CC_ROWSHIFT_count_OutBUS
);

    localparam int W = ROWSHIFT_DATAWIDTH;
    localparam logic [7:0] TICK_LAST = 8'(ROWSHIFT_TICKDIV - 1);

    typedef enum logic [1:0] {
        MODE_HOLD  = 2'b00,
        MODE_LEFT  = 2'b01,
        MODE_RIGHT = 2'b10,
        MODE_LOAD  = 2'b11
    } rowMode;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } rowDir;

    logic [W-1:0] rowReg, rowNext;
    logic [7:0]   countReg, countNext;
    rowDir        dirReg, dirNext, reqDir;
    logic         wrapReg, wrapNext;
    rowMode       modeIn;

    assign modeIn = rowMode'(CC_ROWSHIFT_mode_InBUS);

    // Next-state: load/hold/rotate decisions, prescaler and wrap detection.
    always_comb begin
        rowNext   = rowReg;
        countNext = countReg;
        dirNext   = dirReg;
        wrapNext  = 1'b0;
        reqDir    = (modeIn == MODE_RIGHT) ? DIR_RIGHT : DIR_LEFT;
        case (modeIn)
            MODE_LOAD: begin
                rowNext   = CC_ROWSHIFT_data_InBUS;
                countNext = '0;
            end
            MODE_HOLD: begin
                countNext = '0;
            end
            default: begin
                if (reqDir != dirReg) begin
                    // Direction change burns one cycle and restarts the prescaler.
                    dirNext   = reqDir;
                    countNext = '0;
                end else if (CC_ROWSHIFT_tick_InHigh) begin
                    if (countReg == TICK_LAST) begin
                        countNext = '0;
                        if (reqDir == DIR_LEFT) begin
                            rowNext  = {rowReg[W-2:0], rowReg[W-1]};
                            wrapNext = rowReg[W-1];
                        end else begin
                            rowNext  = {rowReg[0], rowReg[W-1:1]};
                            wrapNext = rowReg[0];
                        end
                    end else begin
                        countNext = countReg + 8'd1;
                    end
                end
            end
        endcase
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge CC_ROWSHIFT_CLOCK_50) begin
        if (CC_ROWSHIFT_RESET_InHigh) begin
            rowReg   <= '0;
            countReg <= '0;
            dirReg   <= DIR_LEFT;
            wrapReg  <= 1'b0;
        end else begin
            rowReg   <= rowNext;
            countReg <= countNext;
            dirReg   <= dirNext;
            wrapReg  <= wrapNext;
        end
    end

    assign CC_ROWSHIFT_data_OutBUS  = rowReg;
    assign CC_ROWSHIFT_count_OutBUS = countReg;
    assign CC_ROWSHIFT_wrap_OutHigh = wrapReg;

endmodule

// File: tb/tb_cc_row_shiftregister.sv
// Self-checking bench for cc_row_shiftregister: directed test-plan
// sequences followed by random stimulus, two DUTs (TICKDIV 4 and 1)
// compared every cycle against a behavioural model.
module tb_cc_row_shiftregister;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] dataIn;
    logic [1:0]   mode;
    logic         tick;

    logic [W-1:0] dataOut [2];
    logic         wrapOut [2];
    logic [7:0]   countOut[2];

    int nChecks = 0;
    int nErrors = 0;

    // Behavioural model state, one set per DUT.
    int mRow [2];
    int mCnt [2];
    int mDir [2];
    int mWrap[2];
    int div  [2] = '{4, 1};

    always #5 clk = ~clk;

    cc_row_shiftregister #(.ROWSHIFT_DATAWIDTH(W), .ROWSHIFT_TICKDIV(4)) dut4 (
        .CC_ROWSHIFT_CLOCK_50    (clk),
        .CC_ROWSHIFT_RESET_InHigh(rst),
        .CC_ROWSHIFT_data_InBUS  (dataIn),
        .CC_ROWSHIFT_mode_InBUS  (mode),
        .CC_ROWSHIFT_tick_InHigh (tick),
        .CC_ROWSHIFT_data_OutBUS (dataOut[0]),
        .CC_ROWSHIFT_wrap_OutHigh(wrapOut[0]),
        .CC_ROWSHIFT_count_OutBUS(countOut[0])
    );

    cc_row_shiftregister #(.ROWSHIFT_DATAWIDTH(W), .ROWSHIFT_TICKDIV(1)) dut1 (
        .CC_ROWSHIFT_CLOCK_50    (clk),
        .CC_ROWSHIFT_RESET_InHigh(rst),
        .CC_ROWSHIFT_data_InBUS  (dataIn),
        .CC_ROWSHIFT_mode_InBUS  (mode),
        .CC_ROWSHIFT_tick_InHigh (tick),
        .CC_ROWSHIFT_data_OutBUS (dataOut[1]),
        .CC_ROWSHIFT_wrap_OutHigh(wrapOut[1]),
        .CC_ROWSHIFT_count_OutBUS(countOut[1])
    );

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nErrors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Apply one row operation to model i, as the behaviour is described.
    task automatic modelStep(input int i);
        int mask;
        mask = (1 << W) - 1;
        if (rst) begin
            mRow[i] = 0; mCnt[i] = 0; mDir[i] = 0; mWrap[i] = 0;
            return;
        end
        mWrap[i] = 0;
        if (mode == 2'b11) begin
            mRow[i] = int'(dataIn); mCnt[i] = 0;
        end else if (mode == 2'b00) begin
            mCnt[i] = 0;
        end else begin
            int want;
            want = (mode == 2'b10) ? 1 : 0;
            if (want != mDir[i]) begin
                mDir[i] = want; mCnt[i] = 0;
            end else if (tick) begin
                mCnt[i] = mCnt[i] + 1;
                if (mCnt[i] == div[i]) begin
                    mCnt[i] = 0;
                    if (want == 0) begin
                        mWrap[i] = (mRow[i] >> (W - 1)) & 1;
                        mRow[i]  = ((mRow[i] * 2) + mWrap[i]) & mask;
                    end else begin
                        mWrap[i] = mRow[i] & 1;
                        mRow[i]  = (mRow[i] / 2) + mWrap[i] * (1 << (W - 1));
                    end
                end
            end
        end
    endtask

    // Drive one cycle, advance the models, compare all outputs after the edge.
    task automatic cycle(input logic r, input logic [1:0] m, input logic [W-1:0] d, input logic t);
        rst = r; mode = m; dataIn = d; tick = t;
        @(posedge clk);
        for (int i = 0; i < 2; i++) modelStep(i);
        #1;
        for (int i = 0; i < 2; i++) begin
            checkVal($sformatf("data%0d", i),  32'(dataOut[i]),  32'(mRow[i]));
            checkVal($sformatf("count%0d", i), 32'(countOut[i]), 32'(mCnt[i]));
            checkVal($sformatf("wrap%0d", i),  32'(wrapOut[i]),  32'(mWrap[i]));
        end
    endtask

    initial begin
        rst = 1'b1; mode = 2'b00; dataIn = '0; tick = 1'b0;

        // Reset then load A5.
        cycle(1'b1, 2'b01, 8'hFF, 1'b1);
        checkVal("rstData", 32'(dataOut[0]), 32'h00);
        cycle(1'b0, 2'b11, 8'hA5, 1'b0);
        checkVal("loadA5", 32'(dataOut[0]), 32'hA5);

        // Rotate left with 4 ticks: counts 1,2,3,0 then 4B with wrap.
        cycle(1'b0, 2'b01, 8'h00, 1'b1); checkVal("cnt1", 32'(countOut[0]), 32'd1);
        cycle(1'b0, 2'b01, 8'h00, 1'b1); checkVal("cnt2", 32'(countOut[0]), 32'd2);
        cycle(1'b0, 2'b01, 8'h00, 1'b1); checkVal("cnt3", 32'(countOut[0]), 32'd3);
        cycle(1'b0, 2'b01, 8'h00, 1'b1);
        checkVal("rotL4B", 32'(dataOut[0]), 32'h4B);
        checkVal("wrapL",  32'(wrapOut[0]), 32'd1);
        cycle(1'b0, 2'b01, 8'h00, 1'b0);
        checkVal("wrapOff", 32'(wrapOut[0]), 32'd0);

        // Load 01, rotate right: 80 with wrap, then 40 without.
        cycle(1'b0, 2'b11, 8'h01, 1'b0);
        cycle(1'b0, 2'b10, 8'h00, 1'b0);       // direction change cycle
        repeat (4) cycle(1'b0, 2'b10, 8'h00, 1'b1);
        checkVal("rotR80", 32'(dataOut[0]), 32'h80);
        checkVal("wrapR",  32'(wrapOut[0]), 32'd1);
        repeat (4) cycle(1'b0, 2'b10, 8'h00, 1'b1);
        checkVal("rotR40", 32'(dataOut[0]), 32'h40);
        checkVal("noWrap", 32'(wrapOut[0]), 32'd0);

        // Load 0F, two left ticks, switch right with tick on switch cycle.
        cycle(1'b0, 2'b11, 8'h0F, 1'b0);
        cycle(1'b0, 2'b01, 8'h00, 1'b0);       // back to left
        repeat (2) cycle(1'b0, 2'b01, 8'h00, 1'b1);
        cycle(1'b0, 2'b10, 8'h00, 1'b1);
        checkVal("swCnt", 32'(countOut[0]), 32'd0);
        checkVal("swRow", 32'(dataOut[0]),  32'h0F);
        repeat (4) cycle(1'b0, 2'b10, 8'h00, 1'b1);
        checkVal("rot87", 32'(dataOut[0]), 32'h87);
        checkVal("wrap87", 32'(wrapOut[0]), 32'd1);

        // Reset mid-prescale discards count; first rotation needs 4 ticks.
        cycle(1'b0, 2'b11, 8'hFF, 1'b0);
        cycle(1'b0, 2'b01, 8'h00, 1'b0);
        repeat (3) cycle(1'b0, 2'b01, 8'h00, 1'b1);
        cycle(1'b1, 2'b01, 8'h00, 1'b1);
        checkVal("rstMidD", 32'(dataOut[0]),  32'h00);
        checkVal("rstMidC", 32'(countOut[0]), 32'd0);
        cycle(1'b0, 2'b11, 8'h80, 1'b0);
        repeat (3) cycle(1'b0, 2'b01, 8'h00, 1'b1);
        checkVal("noRot3", 32'(dataOut[0]), 32'h80);
        cycle(1'b0, 2'b01, 8'h00, 1'b1);
        checkVal("rot01", 32'(dataOut[0]), 32'h01);
        checkVal("wrap01", 32'(wrapOut[0]), 32'd1);

        // Load wins over a terminal tick.
        repeat (3) cycle(1'b0, 2'b01, 8'h00, 1'b1);
        checkVal("preCnt3", 32'(countOut[0]), 32'd3);
        cycle(1'b0, 2'b11, 8'h3C, 1'b1);
        checkVal("ldWinD", 32'(dataOut[0]),  32'h3C);
        checkVal("ldWinC", 32'(countOut[0]), 32'd0);
        checkVal("ldWinW", 32'(wrapOut[0]),  32'd0);

        // Hold clears count: 01 -> 00 -> 01 needs a full prescale again.
        repeat (2) cycle(1'b0, 2'b01, 8'h00, 1'b1);
        cycle(1'b0, 2'b00, 8'h00, 1'b1);
        repeat (3) cycle(1'b0, 2'b01, 8'h00, 1'b1);
        checkVal("holdClr", 32'(dataOut[0]), 32'h3C);

        // Random stimulus.
        for (int n = 0; n < 3000; n++) begin
            logic       r;
            logic [1:0] m;
            int         sel;
            r   = ($urandom_range(0, 99) < 2);
            sel = $urandom_range(0, 99);
            if (sel < 40)      m = 2'b01;
            else if (sel < 75) m = 2'b10;
            else if (sel < 88) m = 2'b00;
            else               m = 2'b11;
            cycle(r, m, W'($urandom), 1'($urandom_range(0, 99) < 70));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nChecks, nErrors);
        $finish;
    end

endmodule

// File: doc/cc_row_shiftregister.md
# cc_row_shiftregister

Registered row stage that sits directly downstream of the 4-to-1 data multiplexer (CC_MUX41) in the RoadFighter datapath. It captures the selected row word and rotates it left or right at a rate set by a tick prescaler, producing the road/obstacle row that scrolls across the display matrix. It also emits a one-cycle wrap pulse whenever a set bit crosses the row edge.

## Interface
- ROWSHIFT_DATAWIDTH, default 8: row width in bits; must match the MUX41 data width feeding this stage.
- ROWSHIFT_TICKDIV, default 4: number of qualifying ticks per rotation step; legal range 1..255.
- CC_ROWSHIFT_CLOCK_50  in  1  system clock; all state changes on the rising edge.
- CC_ROWSHIFT_RESET_InHigh  in  1  synchronous, active-high reset.
- CC_ROWSHIFT_data_InBUS  in  ROWSHIFT_DATAWIDTH  row word from the upstream multiplexer output.
- CC_ROWSHIFT_mode_InBUS  in  2  00 hold, 01 rotate left, 10 rotate right, 11 load.
- CC_ROWSHIFT_tick_InHigh  in  1  rate strobe; counted only in rotate modes.
- CC_ROWSHIFT_data_OutBUS  out  ROWSHIFT_DATAWIDTH  current registered row.
- CC_ROWSHIFT_wrap_OutHigh  out  1  one-cycle pulse on a wrapping rotation.
- CC_ROWSHIFT_count_OutBUS  out  8  current prescaler count, for debug and verification.

## Operation
- State: row register (ROWSHIFT_DATAWIDTH bits), prescaler count (8 bits), last-direction flag (0 = left, 1 = right), wrap register.
- Mode 11 (load): row <= data_InBUS and count <= 0 on the next edge, whatever the tick value. The direction flag is unchanged.
- Mode 00 (hold): row is unchanged and count <= 0.
- Modes 01 and 10 (rotate):
  - If the requested direction differs from the last-direction flag, count <= 0, the flag takes the new direction, and no rotation happens that cycle, even if tick is high.
  - Otherwise, a tick with count < TICKDIV-1 increments count.
  - Otherwise, a tick with count == TICKDIV-1 rotates the row one position and sets count <= 0.
  - With no tick, row and count hold.
- Rotate left: row <= {row[W-2:0], row[W-1]}. Rotate right: row <= {row[0], row[W-1:1]}. This is a pure rotation: no bits are lost and no zero fill.
- Wrap: wrap <= 1 for exactly the cycle after a rotation in which row[W-1] (left) or row[0] (right) was 1. In every other cycle wrap <= 0, including load, hold and direction-change cycles.
- TICKDIV = 1: every tick in a steady direction rotates, and count stays 0.
- All outputs come directly from registers; there is no combinational path from input to output.

## Timing
- Reset, applied at the next edge: data_OutBUS = 0, count_OutBUS = 0, wrap_OutHigh = 0, direction flag = left. Reset overrides every mode and tick.
- Reset during a partial prescale discards the accumulated count; the first rotation after reset needs a full TICKDIV ticks.
- Load latency: data_OutBUS shows the new word 1 cycle after the edge that samples mode 11.
- Rotation latency: the new row and the wrap pulse appear together, 1 cycle after the edge that samples the TICKDIV-th qualifying tick.
- A back-to-back tick every cycle with TICKDIV = N gives one rotation every N cycles.
- Switching between 01 and 10 costs one cycle (the direction-change cycle). Counting restarts from 0 after it.
- Going 01 -> 00 -> 01 clears count without rotating, so a full TICKDIV ticks are needed again.
- Mode 11 and tick high on the same edge: the load wins and the tick is dropped.

## Test plan
- Reset, then load 8'hA5 -> data_OutBUS = 8'hA5 one cycle later; count = 0; wrap = 0.
- Load 8'hA5, mode 01, 4 ticks (TICKDIV = 4) -> data_OutBUS = 8'h4B after the 4th tick; wrap pulses high for 1 cycle; count sequence 1, 2, 3, 0.
- Load 8'h01, mode 10, 4 ticks -> 8'h80 with wrap = 1. Then 4 more ticks -> 8'h40 with wrap = 0.
- Load 8'h0F, mode 01, 2 ticks, then mode 10 with a tick on the switch cycle -> count = 0 and the row stays 8'h0F. Then 4 more ticks -> 8'h87 with wrap = 1.
- Load 8'hFF, mode 01, 3 ticks, then assert reset -> data = 0 and count = 0. Then load 8'h80, mode 01, 3 ticks -> no rotation. The 4th tick -> 8'h01 with wrap = 1.
- Mode 11 with data 8'h3C while tick is high and count = 3 -> data = 8'h3C, count = 0, wrap = 0, with no rotation applied.
